// File: rtl/lsu_dmem_port_if.sv
// Bundle of the core-side request/response handshake and the data memory port
// of the load/store initiator.
interface lsu_dmem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we;
  logic [31:0] drdata;

  // Environment side: drives requests, accepts responses, returns read data.
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, drdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, daddr, dwdata, we
  );

  // Initiator side: the load/store port itself.
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, drdata,
    output req_ready, resp_valid, resp_rdata, resp_err, daddr, dwdata, we
  );
endinterface

// File: rtl/lsu_dmem_port.sv
// Load/store initiator for the word-addressed, byte-lane-enabled data memory.
// One request in flight: accept -> issue -> (wait for read data) -> respond.
module lsu_dmem_port #(
  parameter int DEPTH_BYTES = 128,
  parameter int RD_LAT      = 1
) (
  input  logic          clk,
  input  logic          rst,
  lsu_dmem_port_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0]  LAT   = 2'(RD_LAT);
  localparam logic [31:0] LIMIT = 32'(DEPTH_BYTES);

  // Illegal size, misaligned half/word, or address beyond the memory.
  function automatic logic is_fault(input logic [1:0] size, input logic [31:0] addr);
    logic f;
    f = (size == 2'b11) ||
        (size == 2'b01 && addr[0]) ||
        (size == 2'b10 && addr[1:0] != 2'b00) ||
        (addr >= LIMIT);
    return f;
  endfunction

  // Little-endian byte write enables for a store.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << lo;
      2'b01:   m = lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replicate store data so every enabled lane sees the right bits.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Pick the addressed lane out of the read word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] lo,
                                              input logic uns, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{lo, 3'b000} +: 8];
    h = rd[{lo[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] daddr_q, daddr_d;
  logic [31:0] dwdata_q, dwdata_d;
  logic [3:0]  we_q, we_d;
  logic [1:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        is_store_q, is_store_d;

  // Next-state and next-output logic; every output comes straight from a flop.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    daddr_d      = daddr_q;
    dwdata_d     = dwdata_q;
    we_d         = we_q;
    wait_cnt_d   = wait_cnt_q;
    addr_lo_d    = addr_lo_q;
    size_d       = size_q;
    uns_d        = uns_q;
    is_store_d   = is_store_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_ready_q && bus.req_valid) begin
          req_ready_d  = 1'b0;
          addr_lo_d    = bus.req_addr[1:0];
          size_d       = bus.req_size;
          uns_d        = bus.req_unsigned;
          is_store_d   = bus.req_we;
          resp_rdata_d = 32'h0;
          if (is_fault(bus.req_size, bus.req_addr)) begin
            // Faults never reach the memory; answer right away.
            resp_err_d   = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            resp_err_d = 1'b0;
            daddr_d    = {bus.req_addr[31:2], 2'b00};
            if (bus.req_we) begin
              we_d     = lane_mask(bus.req_size, bus.req_addr[1:0]);
              dwdata_d = lane_data(bus.req_size, bus.req_wdata);
            end
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        // The write (if any) happens in this single cycle.
        we_d = 4'b0000;
        if (is_store_q) begin
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          wait_cnt_d = 2'd1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == LAT) begin
          resp_rdata_d = load_extend(size_q, addr_lo_q, uns_q, bus.drdata);
          resp_valid_d = 1'b1;
          wait_cnt_d   = 2'd0;
          state_d      = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'h0;
          resp_err_d   = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any request in flight at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      daddr_q      <= 32'h0;
      dwdata_q     <= 32'h0;
      we_q         <= 4'b0000;
      wait_cnt_q   <= 2'd0;
      addr_lo_q    <= 2'd0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      is_store_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      daddr_q      <= daddr_d;
      dwdata_q     <= dwdata_d;
      we_q         <= we_d;
      wait_cnt_q   <= wait_cnt_d;
      addr_lo_q    <= addr_lo_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      is_store_q   <= is_store_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.daddr      = daddr_q;
  assign bus.dwdata     = dwdata_q;
  assign bus.we         = we_q;
endmodule

// File: tb/tb_lsu_dmem_port.sv
// Bench for lsu_dmem_port: one instance with a 1-cycle memory, one with a
// 2-cycle memory, a byte-level reference model and a response scoreboard.
module tb_lsu_dmem_port;
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lsu_dmem_port_if d0 ();
  lsu_dmem_port_if d1 ();

  lsu_dmem_port #(.DEPTH_BYTES(128), .RD_LAT(1)) u_dut0 (.clk(clk), .rst(rst), .bus(d0));
  lsu_dmem_port #(.DEPTH_BYTES(128), .RD_LAT(2)) u_dut1 (.clk(clk), .rst(rst), .bus(d1));

  // Memories: mem0 is written by dut0, mem1 is preloaded and read-only.
  logic [7:0]  mem0 [128];
  logic [7:0]  mem1 [128];
  logic [31:0] rd0, rd1a, rd1b;

  always @(posedge clk) begin
    for (int n = 0; n < 4; n++)
      if (d0.we[n]) mem0[{d0.daddr[6:2], 2'(n)}] <= d0.dwdata[8*n +: 8];
    rd0  <= {mem0[{d0.daddr[6:2], 2'd3}], mem0[{d0.daddr[6:2], 2'd2}],
             mem0[{d0.daddr[6:2], 2'd1}], mem0[{d0.daddr[6:2], 2'd0}]};
    rd1a <= {mem1[{d1.daddr[6:2], 2'd3}], mem1[{d1.daddr[6:2], 2'd2}],
             mem1[{d1.daddr[6:2], 2'd1}], mem1[{d1.daddr[6:2], 2'd0}]};
    rd1b <= rd1a;
  end
  assign d0.drdata = rd0;
  assign d1.drdata = rd1b;

  // Reference byte image of mem0 as the bench expects it.
  logic [7:0] sh [128];

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic model_fault(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && a[0] == 1'b1) return 1'b1;
    if (sz == 2'd2 && a[1:0] != 2'd0) return 1'b1;
    if (a >= 32'd128) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic un, input logic [31:0] a);
    int i;
    logic [31:0] v;
    i = int'(a[6:0]);
    if (sz == 2'd0)      v = un ? {24'h0, sh[i]} : {{24{sh[i][7]}}, sh[i]};
    else if (sz == 2'd1) v = un ? {16'h0, sh[i+1], sh[i]} : {{16{sh[i+1][7]}}, sh[i+1], sh[i]};
    else                 v = {sh[i+3], sh[i+2], sh[i+1], sh[i]};
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int i;
    int nb;
    i  = int'(a[6:0]);
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int k = 0; k < nb; k++) sh[i+k] = wd[8*k +: 8];
  endtask

  // Response monitor: every dut0 handshake is matched against the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && d0.resp_valid && d0.resp_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_resp", 32'(d0.resp_valid), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("resp_rdata", d0.resp_rdata, e.rdata);
        chk("resp_err", 32'(d0.resp_err), 32'(e.err));
      end
    end
  end

  // One dut0 transaction; stall > 0 holds resp_ready low for that many cycles.
  task automatic xact(input string tag, input logic w, input logic [1:0] sz, input logic un,
                      input logic [31:0] a, input logic [31:0] wd, input int stall);
    logic        flt;
    logic [3:0]  mask;
    logic [31:0] rep, er;
    logic [3:0]  we_acc;
    int          lat, to, exp_lat;
    flt  = model_fault(sz, a);
    mask = (sz == 2'd0) ? (4'b0001 << a[1:0]) : (sz == 2'd1) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    rep  = (sz == 2'd0) ? {4{wd[7:0]}} : (sz == 2'd1) ? {2{wd[15:0]}} : wd;
    er   = 32'h0;
    if (!flt && !w) er = model_load(sz, un, a);
    if (!flt && w) model_store(sz, a, wd);
    exp_lat = flt ? 1 : (w ? 2 : 3);

    @(negedge clk);
    d0.req_valid = 1'b1; d0.req_we = w; d0.req_size = sz; d0.req_unsigned = un;
    d0.req_addr = a; d0.req_wdata = wd;
    to = 0;
    while (!d0.req_ready && to < 20) begin @(negedge clk); to++; end
    chk({tag, "_ready"}, 32'(d0.req_ready), 32'd1);
    @(posedge clk); #1;
    d0.req_valid = 1'b0;
    d0.req_wdata = 32'h0BAD_0BAD;
    sbq.push_back('{rdata: er, err: flt});

    lat = 0; we_acc = 4'b0000;
    do begin
      @(negedge clk);
      lat++;
      we_acc |= d0.we;
      if (lat == 1) begin
        chk({tag, "_c1_ready"}, 32'(d0.req_ready), 32'd0);
        if (!flt) chk({tag, "_daddr"}, d0.daddr, {a[31:2], 2'b00});
        if (!flt && w) begin
          chk({tag, "_we"}, 32'(d0.we), 32'(mask));
          chk({tag, "_dwdata"}, d0.dwdata, rep);
        end
      end
    end while (!d0.resp_valid && lat < 20);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_we_total"}, 32'(we_acc), (w && !flt) ? 32'(mask) : 32'd0);
    chk({tag, "_we_resp"}, 32'(d0.we), 32'd0);

    if (stall > 0) begin
      // A request offered during the stall must be ignored.
      d0.req_valid = 1'b1; d0.req_we = 1'b1; d0.req_size = 2'd2;
      d0.req_addr = 32'h0; d0.req_wdata = 32'h5555_5555;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        chk({tag, "_bp_valid"}, 32'(d0.resp_valid), 32'd1);
        chk({tag, "_bp_rdata"}, d0.resp_rdata, er);
        chk({tag, "_bp_ready"}, 32'(d0.req_ready), 32'd0);
        chk({tag, "_bp_we"}, 32'(d0.we), 32'd0);
      end
      d0.req_valid = 1'b0;
      @(posedge clk); #1;
      d0.resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_ready_after"}, 32'(d0.req_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int to;
    rst = 1'b1;
    d0.req_valid = 1'b0; d0.req_we = 1'b0; d0.req_size = 2'd0; d0.req_unsigned = 1'b0;
    d0.req_addr = 32'h0; d0.req_wdata = 32'h0; d0.resp_ready = 1'b1;
    d1.req_valid = 1'b0; d1.req_we = 1'b0; d1.req_size = 2'd0; d1.req_unsigned = 1'b0;
    d1.req_addr = 32'h0; d1.req_wdata = 32'h0; d1.resp_ready = 1'b1;
    for (int i = 0; i < 128; i++) sh[i] = 8'h00;
    mem1[32] = 8'hF0; mem1[33] = 8'h80; mem1[34] = 8'h34; mem1[35] = 8'h12;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(d0.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(d0.resp_valid), 32'd0);
    chk("rst_resp_rdata", d0.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(d0.resp_err), 32'd0);
    chk("rst_daddr", d0.daddr, 32'd0);
    chk("rst_dwdata", d0.dwdata, 32'd0);
    chk("rst_we", 32'(d0.we), 32'd0);
    chk("rst_req_ready1", 32'(d1.req_ready), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", 32'(d0.req_ready), 32'd1);

    xact("st_w10",  1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
    xact("st_b13",  1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00A5, 0);
    xact("ld_b13s", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0);
    xact("ld_b13u", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
    xact("st_w10b", 1'b1, 2'd2, 1'b0, 32'h10, 32'h8001_1234, 0);
    xact("ld_h12s", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0);
    xact("ld_h10s", 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 0);
    xact("ld_h11",  1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 0);
    xact("ld_w80",  1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 0);
    xact("st_sz3",  1'b1, 2'd3, 1'b0, 32'h14, 32'h1234_5678, 0);
    xact("ld_w12",  1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 0);
    xact("st_w14",  1'b1, 2'd2, 1'b0, 32'h14, 32'h1122_3344, 0);
    xact("st_h16",  1'b1, 2'd1, 1'b0, 32'h16, 32'h0000_CAFE, 0);
    xact("st_b15",  1'b1, 2'd0, 1'b0, 32'h15, 32'h0000_0077, 0);
    xact("ld_w14",  1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0);
    xact("ld_h16u", 1'b0, 2'd1, 1'b1, 32'h16, 32'h0, 0);
    xact("ld_b16s", 1'b0, 2'd0, 1'b0, 32'h16, 32'h0, 0);
    xact("ld_b11u", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 0);

    d0.resp_ready = 1'b0;
    xact("bp_w10",  1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 3);

    // Reset while a load waits for its read data: the load is dropped.
    @(negedge clk);
    d0.req_valid = 1'b1; d0.req_we = 1'b0; d0.req_size = 2'd2; d0.req_addr = 32'h10;
    @(posedge clk); #1;
    d0.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_resp_valid", 32'(d0.resp_valid), 32'd0);
    chk("mid_rst_ready", 32'(d0.req_ready), 32'd0);
    chk("mid_rst_daddr", d0.daddr, 32'd0);
    chk("mid_rst_we", 32'(d0.we), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("after_rst_no_resp", 32'(d0.resp_valid), 32'd0);
    end
    chk("after_rst_ready", 32'(d0.req_ready), 32'd1);

    // Two-cycle memory: signed half load from preloaded 0x1234_80F0.
    @(negedge clk);
    d1.req_valid = 1'b1; d1.req_we = 1'b0; d1.req_size = 2'd1; d1.req_unsigned = 1'b0;
    d1.req_addr = 32'h20;
    to = 0;
    while (!d1.req_ready && to < 20) begin @(negedge clk); to++; end
    chk("lat2_ready", 32'(d1.req_ready), 32'd1);
    @(posedge clk); #1;
    d1.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!d1.resp_valid && lat < 20);
    chk("lat2_lat", 32'(lat), 32'd4);
    chk("lat2_rdata", d1.resp_rdata, 32'hFFFF_80F0);
    chk("lat2_err", 32'(d1.resp_err), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat2_ready_after", 32'(d1.req_ready), 32'd1);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
